// File: rtl/fib_kb_ctrl_pkg.sv
// Shared constants for the keyboard -> Fibonacci -> UART sequencer:
// scan codes, ASCII bytes, FSM encoding and result-nibble helpers.
package fib_ctrl_pkg;

  // Make codes for digits 0..9 (index = digit value)
  localparam logic [9:0][7:0] SC_DIGIT = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  typedef enum logic [2:0] {COLLECT, CHECK, START, WAIT, SEND, ERR, EOL} state_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_enter;
    logic       is_clear;
  } key_t;

  function automatic int nib_count(int w);
    return (w + 3) / 4;
  endfunction

  function automatic logic [7:0] hex_ascii(logic [3:0] n);
    return (n < 4'd10) ? ASC_0 + {4'd0, n} : ASC_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/fib_kb_ctrl_if.sv
// Bundle of the keyboard FIFO, Fibonacci unit and UART TX signals seen by the
// sequencer; master = controller side, slave = environment side.
interface fib_kb_ctrl_if #(parameter int FIB_W = 20);
  logic             kb_buf_empty;
  logic [7:0]       key_code;
  logic             rd_key_code;
  logic             fib_ready;
  logic             fib_done_tick;
  logic [FIB_W-1:0] fib_f;
  logic             fib_start;
  logic [5:0]       fib_i;
  logic             tx_full;
  logic             wr_uart;
  logic [7:0]       w_data;
  logic             busy;
  logic             err;

  modport master (
    input  kb_buf_empty, key_code, fib_ready, fib_done_tick, fib_f, tx_full,
    output rd_key_code, fib_start, fib_i, wr_uart, w_data, busy, err
  );
  modport slave (
    output kb_buf_empty, key_code, fib_ready, fib_done_tick, fib_f, tx_full,
    input  rd_key_code, fib_start, fib_i, wr_uart, w_data, busy, err
  );
endinterface

// File: rtl/fib_kb_ctrl_decode.sv
// Combinational classification of the make code at the keyboard FIFO head.
module kb_digit_decode
  import fib_ctrl_pkg::*;
(
  input  logic [7:0] key_code,
  output key_t       key
);

  always_comb begin
    key          = '0;
    key.is_enter = (key_code == SC_ENTER);
    key.is_clear = (key_code == SC_BKSP) || (key_code == SC_ESC);
    for (int i = 0; i < 10; i++) begin
      if (key_code == SC_DIGIT[i]) begin
        key.is_digit = 1'b1;
        key.digit    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/fib_kb_ctrl.sv
// Keyboard-driven Fibonacci sequencer: collects a 1-2 digit index, runs the
// Fibonacci unit, prints the result as hex + CR. FIB_CTRL_ECHO_EN echoes digits.
module fib_kb_ctrl
  import fib_ctrl_pkg::*;
#(
  parameter int FIB_W   = 20,
  parameter int MAX_IDX = 30
) (
  input logic          clk,
  input logic          reset,
  fib_kb_ctrl_if.master bus
);

  localparam int NIB    = nib_count(FIB_W);
  localparam int NIB_BW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NIB_BW-1:0] NIB_LAST = NIB_BW'(NIB - 1);
  localparam logic [6:0]        MAX_ACC  = 7'(MAX_IDX);

  state_t             state;
  logic [6:0]         acc;
  logic [1:0]         cnt;
  logic [FIB_W-1:0]   result;
  logic [NIB_BW-1:0]  nib;
  logic [NIB*4-1:0]   res_ext;
  logic [3:0]         cur_nib;
  key_t               key;
  logic               pop, can_tx;
  logic               fib_start_r, wr_r, busy_r, err_r;
  logic [5:0]         fib_i_r;
  logic [7:0]         wd_r;

  kb_digit_decode u_dec (.key_code(bus.key_code), .key(key));

  assign can_tx = !bus.tx_full;
`ifdef FIB_CTRL_ECHO_EN
  // A key is only taken when its echo byte can be written in the same cycle
  assign pop = (state == COLLECT) && !bus.kb_buf_empty && can_tx;
`else
  assign pop = (state == COLLECT) && !bus.kb_buf_empty;
`endif

  assign res_ext = (NIB*4)'(result);
  assign cur_nib = 4'(res_ext >> {nib, 2'b00});

  assign bus.rd_key_code = pop;
  assign bus.fib_start   = fib_start_r;
  assign bus.fib_i       = fib_i_r;
  assign bus.wr_uart     = wr_r;
  assign bus.w_data      = wd_r;
  assign bus.busy        = busy_r;
  assign bus.err         = err_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      acc         <= '0;
      cnt         <= '0;
      result      <= '0;
      nib         <= '0;
      fib_start_r <= 1'b0;
      fib_i_r     <= '0;
      wr_r        <= 1'b0;
      wd_r        <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      fib_start_r <= 1'b0;
      wr_r        <= 1'b0;
      case (state)
        COLLECT: if (pop) begin
          if (key.is_digit) begin
            if (cnt < 2'd2) begin
              acc <= acc * 7'd10 + {3'b000, key.digit};
              cnt <= cnt + 2'd1;
`ifdef FIB_CTRL_ECHO_EN
              wr_r <= 1'b1;
              wd_r <= ASC_0 + {4'd0, key.digit};
`endif
            end
          end else if (key.is_clear) begin
            acc <= '0;
            cnt <= '0;
          end else if (key.is_enter && cnt != 2'd0) begin
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: state <= (acc > MAX_ACC) ? ERR : START;
        START: if (bus.fib_ready) begin
          fib_i_r     <= acc[5:0];
          fib_start_r <= 1'b1;
          state       <= WAIT;
        end
        WAIT: if (bus.fib_done_tick) begin
          result <= bus.fib_f;
          nib    <= NIB_LAST;
          state  <= SEND;
        end
        // Most significant nibble first, leading zeros included
        SEND: if (can_tx) begin
          wr_r <= 1'b1;
          wd_r <= hex_ascii(cur_nib);
          if (nib == '0) state <= EOL;
          else           nib   <= nib - NIB_BW'(1);
        end
        ERR: if (can_tx) begin
          wr_r  <= 1'b1;
          wd_r  <= ASC_E;
          err_r <= 1'b1;
          state <= EOL;
        end
        EOL: if (can_tx) begin
          wr_r   <= 1'b1;
          wd_r   <= ASC_CR;
          acc    <= '0;
          cnt    <= '0;
          busy_r <= 1'b0;
          state  <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/fib_kb_ctrl.md
Name: fib_kb_ctrl

Overview:
- Sequencer between the PS/2 scan-code FIFO, the Fibonacci unit and the UART transmitter.
- Pops make codes from the keyboard FIFO and accumulates up to two decimal digits into an index.
- On Enter: range-checks the index, starts the Fibonacci unit and waits for its result.
- Streams the result to the UART as uppercase ASCII hex, terminated by CR. Replaces free-running key-code pairing with a per-key-event controller.

Parameters:
FIB_W, 20, width of the Fibonacci result bus (F(30)=832040 fits in 20 bits)
MAX_IDX, 30, largest accepted index; anything larger is an error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
kb_buf_empty  in  1  keyboard FIFO empty
key_code  in  8  make code at FIFO head (break codes already stripped)
rd_key_code  out  1  pop FIFO; key_code is sampled on the same edge
fib_ready  in  1  Fibonacci unit idle
fib_done_tick  in  1  one-cycle result-valid pulse
fib_f  in  FIB_W  Fibonacci result
fib_start  out  1  one-cycle start pulse
fib_i  out  6  index presented to the Fibonacci unit
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  one-cycle UART write
w_data  out  8  ASCII byte to the UART
busy  out  1  high in every state except COLLECT
err  out  1  high from entering ERR until the next Enter with at least one digit is accepted

Behaviour:
- Clock and reset: single clock domain clk; reset is synchronous and active-high. Reset values: all outputs 0, state COLLECT, digit count 0, accumulator 0, result 0.
- Reset mid-operation: returns to COLLECT and discards any partial entry or result. FIFO contents are untouched, and no further wr_uart or fib_start is issued.
- rd_key_code: combinational, equal to (state==COLLECT && !kb_buf_empty). All other outputs are registered.
- Scan codes: digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46 (hex); Enter=5A; Backspace=66; Escape=76.
- COLLECT, on each pop:
  - Digit: if count<2, acc <= acc*10+d (7-bit accumulator) and count++. A third or later digit is popped and ignored.
  - Backspace or Escape: acc <= 0, count <= 0.
  - Enter with count==0: ignored.
  - Enter with count>0: clear err, go to CHECK.
  - Any other code: popped and ignored.
- CHECK: acc>MAX_IDX goes to ERR; otherwise go to START.
- START: wait for fib_ready. When it is seen, fib_i <= acc[5:0] and fib_start pulses for 1 cycle; go to WAIT.
- WAIT: on fib_done_tick, latch fib_f into the result register and go to SEND with nibble index NIB-1, where NIB=(FIB_W+3)/4. A fib_done_tick in any other state is ignored.
- SEND:
  - Each byte needs one cycle with !tx_full: wr_uart=1 and w_data=hex ASCII of the nibble, MSB first, zero-extended; leading zeros are sent.
  - While tx_full is high, hold with wr_uart=0.
  - After nibble 0, go to EOL.
- ERR: write 'E' (45h) under the same tx_full rule, set err, go to EOL.
- EOL: write 0Dh, then clear acc and count and return to COLLECT.
- Throughput: at most one UART byte per cycle. No key is popped while busy, so keys queue in the FIFO.

Optional Feature:
- Macro: FIB_CTRL_ECHO_EN.
- Defined: every accepted digit is echoed to the UART as ASCII '0'-'9' in the cycle it is popped. rd_key_code additionally requires !tx_full, so a key whose echo cannot be written is not popped. Ignored keys, Enter and Backspace are not echoed.
- Undefined: no echo, and rd_key_code ignores tx_full.

Decomposition:
- Package fib_ctrl_pkg:
  - scan-code constants (digits, ENTER, BKSP, ESC)
  - ASCII constants (CR, 'E', '0', 'A')
  - state encoding COLLECT/CHECK/START/WAIT/SEND/ERR/EOL
  - NIB derivation
- Sub-module kb_digit_decode: combinational key_code to {is_digit, digit[3:0], is_enter, is_clear}.
- Main FSM, accumulator, nibble counter and hex-to-ASCII conversion stay in fib_kb_ctrl.

Test Plan:
- Keys 16,1E,5A ("1","2",Enter) with fib_f=20'h00090 on done → fib_i=12, exactly one fib_start pulse; UART bytes "0","0","0","9","0",0Dh.
- Keys 25,2E,5A ("45") → err=1, no fib_start, UART bytes 45h,0Dh. Then "3",Enter → err=0, fib_i=3.
- Keys "1","2","3",Enter → third digit ignored, fib_i=12. Keys "7",66,"5",Enter → fib_i=5. A lone Enter → no activity.
- tx_full held high for 10 cycles during SEND → wr_uart stays 0; bytes resume in order with none lost or duplicated. fib_ready low delays fib_start until it rises.
- Reset asserted in WAIT, then fib_done_tick → no UART bytes; next "8",Enter → fib_i=8.
- FIB_CTRL_ECHO_EN defined: "2","9",Enter → UART 32h,39h, then the result hex and 0Dh. With tx_full high, kb_buf_empty=0 yields rd_key_code=0.
